// File: rtl/res_bank_pkg.sv
// rtl/res_bank_pkg.sv - shared types and saturation limit helpers for res_bank
package res_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Most positive value of a w-bit signed number
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit signed number
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/res_bank_add.sv
// rtl/res_bank_add.sv - signed adder with overflow detect; RES_SAT_EN selects saturate instead of wrap
module res_bank_add
  import res_bank_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] full;

  // Sign-extend both operands so the WIDTH+1-bit sum is exact
  always_comb begin
    full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf  = full[WIDTH] != full[WIDTH-1];
  end

`ifdef RES_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

  // On overflow clamp toward the sign of the true sum
  always_comb begin
    sum = full[WIDTH-1:0];
    if (ovf) sum = full[WIDTH] ? SAT_LO : SAT_HI;
  end
`else
  // Wrap modulo 2^WIDTH by dropping the extra bit
  always_comb begin
    sum = full[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/res_bank.sv
// rtl/res_bank.sv - result-register bank with overwrite/accumulate writes and valid/ready drain (RES_SAT_EN: saturating accumulate)
module res_bank
  import res_bank_pkg::*;
#(
  parameter  int WIDTH  = 18,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_res,
  input  logic              wr_en,
  input  logic              wr_acc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              drain_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              wr_ok;
  logic [WIDTH-1:0]  old_val;
  logic [WIDTH-1:0]  add_sum;
  logic              add_ovf;
  logic [WIDTH-1:0]  new_val;
  logic              set_ovf;
  logic              last_idx;

  // Pick the accumulate base (zero when a clear lands in the same cycle) and the value to store
  always_comb begin
    wr_ok   = int'(wr_addr) < DEPTH;
    old_val = (clear_res || !wr_ok) ? '0 : mem[wr_addr];
    new_val = wr_acc ? add_sum : data_in;
    set_ovf = wr_en && wr_acc && add_ovf && !clear_res;
  end

  res_bank_add #(.WIDTH(WIDTH)) u_add (
    .a   (old_val),
    .b   (data_in),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Entry storage: writes and clears only land while idle so a drain sees frozen contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == IDLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear_res) mem[i] <= '0;
        if (wr_en && wr_ok && (int'(wr_addr) == i)) mem[i] <= new_val;
      end
    end
  end

  // Sticky overflow flag, cleared by reset or clear_res
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state_q == IDLE) begin
      if (clear_res)    ovf <= 1'b0;
      else if (set_ovf) ovf <= 1'b1;
    end
  end

  // State and drain index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and drain outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_idx  = idx_q == ADDR_W'(DEPTH - 1);
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_addr  = idx_q;
    out_data  = mem[idx_q];
    case (state_q)
      IDLE: begin
        if (drain_start) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = last_idx;
        if (out_ready) begin
          if (last_idx) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_res_bank.sv
// tb/tb_res_bank.sv - randomized self-checking bench for res_bank with a behavioural model
module tb_res_bank;

  localparam int WIDTH  = 18;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int MAXV   = 131071;
  localparam int MINV   = -131072;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear_res = 1'b0;
  logic              wr_en = 1'b0;
  logic              wr_acc = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  data_in = '0;
  logic              drain_start = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  res_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_res   (clear_res),
    .wr_en       (wr_en),
    .wr_acc      (wr_acc),
    .wr_addr     (wr_addr),
    .data_in     (data_in),
    .drain_start (drain_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer contents plus a snapshot of the stream being drained
  int m [DEPTH];
  int snap [DEPTH];
  bit m_ovf = 0;
  bit draining = 0;
  int pos = 0;
  bit model_live = 0;

  function automatic int wrap18(input int s);
    int t;
    t = s & 32'h3FFFF;
    if (t > MAXV) t -= 262144;
    return t;
  endfunction

  always @(posedge clk) begin
    int a, d, old, s;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m[i] = 0;
      m_ovf = 0;
      draining = 0;
      pos = 0;
      model_live = 1;
    end else if (draining) begin
      if (out_ready) begin
        pos++;
        if (pos == DEPTH) begin
          draining = 0;
          pos = 0;
        end
      end
    end else begin
      a = int'(wr_addr);
      d = int'($signed(data_in));
      if (clear_res) begin
        for (int i = 0; i < DEPTH; i++) m[i] = 0;
        m_ovf = 0;
      end
      if (wr_en) begin
        old = m[a];
        if (wr_acc) begin
          s = old + d;
          if (s > MAXV || s < MINV) begin
            m_ovf = 1;
`ifdef RES_SAT_EN
            m[a] = (s > MAXV) ? MAXV : MINV;
`else
            m[a] = wrap18(s);
`endif
          end else begin
            m[a] = s;
          end
        end else begin
          m[a] = d;
        end
      end
      if (drain_start) begin
        draining = 1;
        pos = 0;
        for (int i = 0; i < DEPTH; i++) snap[i] = m[i];
      end
    end
  end

  // Compare every cycle at the falling edge; also check that a stalled beat holds
  bit              p_stall = 0;
  logic [WIDTH-1:0] p_data;
  logic [ADDR_W-1:0] p_addr;
  logic            p_last;

  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", int'(out_valid), int'(draining));
      chk("busy", int'(busy), int'(draining));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (draining) begin
        chk("out_addr", int'(out_addr), pos);
        chk("out_data", int'($signed(out_data)), snap[pos]);
        chk("out_last", int'(out_last), int'(pos == DEPTH - 1));
      end else begin
        chk("idle_out_last", int'(out_last), 0);
        chk("idle_out_addr", int'(out_addr), 0);
      end
      if (p_stall && out_valid) begin
        chk("stall_hold_data", int'(out_data), int'(p_data));
        chk("stall_hold_addr", int'(out_addr), int'(p_addr));
        chk("stall_hold_last", int'(out_last), int'(p_last));
      end
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_addr  = out_addr;
      p_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input bit acc, input int addr, input int val);
    wr_en = 1; wr_acc = acc; wr_addr = ADDR_W'(addr); data_in = WIDTH'(val);
    tick();
    wr_en = 0; wr_acc = 0;
  endtask

  int got [DEPTH];

  // mode 0: always ready; 1: ready 1,0,0,... with stray writes/clears; 2: random ready
  task automatic drain(input int mode, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < DEPTH; i++) got[i] = -999999;
    drain_start = 1;
    tick();
    drain_start = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      case (mode)
        0:       out_ready = 1;
        1:       out_ready = (c % 3) == 0;
        default: out_ready = $urandom_range(0, 1);
      endcase
      if (mode == 1) begin
        wr_en = $urandom_range(0, 1);
        wr_acc = $urandom_range(0, 1);
        clear_res = $urandom_range(0, 1);
        drain_start = $urandom_range(0, 1);
        wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        data_in = WIDTH'($urandom);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got[int'(out_addr)] = int'($signed(out_data));
        n++;
        if (out_last) done = 1;
      end
      tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
    out_ready = 0; wr_en = 0; clear_res = 0; drain_start = 0;
  endtask

  initial begin
    int n;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_out_addr", int'(out_addr), 0);
    tick();

    // Reset contents drain as zeros
    drain(0, n);
    chk("t1_beats", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("t1_zero", got[i], 0);
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);
    tick();

    // Overwrite then accumulate twice
    write(0, 2, 100);
    write(1, 2, -30);
    write(1, 2, -30);
    drain(0, n);
    chk("t2_entry2", got[2], 40);
    chk("t2_model_entry2", m[2], 40);
    chk("t2_ovf", int'(ovf), 0);

    // Accumulate past the positive limit
    write(0, 0, 131000);
    write(1, 0, 100);
    drain(0, n);
`ifdef RES_SAT_EN
    chk("t3_entry0", got[0], 131071);
`else
    chk("t3_entry0", got[0], -131044);
`endif
    chk("t3_ovf", int'(ovf), 1);

    // Clear and accumulate in the same cycle
    for (int i = 0; i < DEPTH; i++) write(0, i, 5);
    clear_res = 1;
    write(1, 1, 7);
    clear_res = 0;
    drain(0, n);
    chk("t4_e0", got[0], 0);
    chk("t4_e1", got[1], 7);
    chk("t4_e2", got[2], 0);
    chk("t4_e3", got[3], 0);
    chk("t4_ovf", int'(ovf), 0);

    // Stalled drain with writes/clears that must be ignored
    drain(1, n);
    chk("t5_beats", n, DEPTH);
    chk("t5_e1", got[1], 7);
    chk("t5_e0", got[0], 0);
    tick();

    // Reset on the second drain beat
    write(0, 3, 9);
    drain_start = 1;
    tick();
    drain_start = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_busy", int'(busy), 0);
    tick();
    drain(0, n);
    for (int i = 0; i < DEPTH; i++) chk("t6_zero", got[i], 0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      clear_res = ($urandom_range(0, 15) == 0);
      wr_en = $urandom_range(0, 1);
      wr_acc = $urandom_range(0, 2) != 0;
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 3))
        0: data_in = WIDTH'(MAXV);
        1: data_in = WIDTH'(MINV);
        2: data_in = WIDTH'($urandom_range(0, 200) - 100);
        default: data_in = WIDTH'($urandom);
      endcase
      drain_start = ($urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 0; clear_res = 0; wr_en = 0; drain_start = 0; out_ready = 0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/res_bank.md
Name: res_bank

Overview:
- Parametrised result-register bank; successor to the single 18-bit result register in the matrix-multiply datapath.
- Holds DEPTH result entries (e.g. one per element of the output matrix).
- Each entry is written either by overwrite or by signed accumulate of partial products.
- Contents are streamed out in address order over a valid/ready drain interface.

Parameters:
- WIDTH, 18, entry and data width, signed two's complement.
- DEPTH, 4, number of entries; must be at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_res  in  1  zero all entries and ovf in one cycle.
- wr_en  in  1  write/accumulate strobe.
- wr_acc  in  1  1 = mem[wr_addr] += data_in; 0 = mem[wr_addr] = data_in.
- wr_addr  in  ADDR_W  target entry.
- data_in  in  WIDTH  write data (signed).
- drain_start  in  1  start streaming entries 0..DEPTH-1.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  WIDTH  entry at out_addr.
- out_addr  out  ADDR_W  index of current beat.
- out_last  out  1  high with out_valid on the entry DEPTH-1 beat.
- busy  out  1  high while in DRAIN.
- ovf  out  1  sticky signed-overflow flag from accumulate.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset, when rst is sampled high: all entries 0, state IDLE, idx 0. Resulting outputs: out_valid 0, out_last 0, busy 0, ovf 0, out_addr 0. rst has priority over every other input.
- States: IDLE and DRAIN.
- IDLE, clear_res only: all entries become 0 and ovf becomes 0 at the edge.
- IDLE, wr_en only: entry updated at the edge. The new value is visible to a drain started on the next cycle.
- IDLE, clear_res and wr_en in the same cycle:
  - The addressed entry receives data_in; accumulate treats the old value as 0.
  - All other entries clear.
  - ovf clears; it is not set by this write.
- Accumulate arithmetic:
  - Full WIDTH+1-bit signed sum is formed.
  - Overflow = sum does not fit in WIDTH signed bits; overflow sets ovf, which stays set until rst or clear_res.
  - Overwrite never sets ovf.
- IDLE, drain_start: go to DRAIN with idx=0. out_valid rises the following cycle.
  - If drain_start coincides with wr_en or clear_res, the write/clear takes effect first. The drain then reads the updated contents.
- DRAIN outputs: out_valid=1, busy=1, out_addr=idx, out_data=mem[idx] (combinational read of flops), out_last=(idx==DEPTH-1).
- DRAIN handshake: a beat transfers when out_valid && out_ready.
  - On transfer with idx<DEPTH-1: idx increments.
  - On transfer with idx==DEPTH-1: return to IDLE and clear idx. out_valid is low the next cycle.
  - out_ready low: out_data, out_addr and out_last hold stable.
- DRAIN ignores wr_en, clear_res and drain_start; contents are frozen. Upstream must check busy.
- Back-to-back drains: drain_start can be accepted in the cycle after returning to IDLE, giving a one-cycle gap minimum.
- rst during DRAIN: immediate return to IDLE, entries zeroed. The partial stream is abandoned, with no out_last.

Optional Feature:
- Macro: RES_SAT_EN.
- Defined: on accumulate overflow the entry saturates to +2^(WIDTH-1)-1 or -2^(WIDTH-1), following the sign of the true sum.
- Undefined: the entry wraps modulo 2^WIDTH.
- ovf behaves identically in both builds.

Decomposition:
- Package res_bank_pkg holds:
  - State enum typedef (IDLE, DRAIN).
  - Function computing the saturation limits from WIDTH.
- One sub-module, res_bank_add: WIDTH-bit signed add with overflow detect and RES_SAT_EN-controlled saturate/wrap. It is combinational and instantiated once, shared by all entries, because only one write per cycle is possible.

Test Plan:
- Reset then drain with out_ready=1 -> 4 beats, addr 0..3, data all 0, out_last only on addr 3, busy drops after the last beat.
- Overwrite addr2=100, then accumulate addr2 +=-30 twice -> drain shows entry2=40, ovf=0.
- Accumulate addr0: 131000 then +100 -> RES_SAT_EN: entry0=131071; without: entry0=-131044 (wrap); ovf=1 in both.
- Same-cycle clear_res and wr_en acc addr1=7 with all entries at 5 -> entries {0,7,0,0}, ovf=0.
- Drain with out_ready toggling 1,0,0,1,... plus wr_en pulses during DRAIN -> data/addr held while stalled, writes ignored, exactly DEPTH transfers.
- rst asserted on 2nd drain beat -> next cycle out_valid=0, busy=0; a new drain returns all zeros.
